// File: rtl/outfifo_uart_frame_tx.sv
// outfifo_uart_frame_tx: drains one frame of FRAME_WORDS FIFO words over a UART line, DW/8 bytes per word.
// Define UART_PARITY_EN for 8E1 framing; the default build is 8N1.
module outfifo_uart_frame_tx #(
  parameter int CLK_FREQ_FPGA = 10000000,
  parameter int BAUDRATE      = 115200,
  parameter int DW            = 32,
  parameter int FRAME_WORDS   = 223,
  parameter bit MSB_FIRST     = 1'b0
) (
  input  logic                               out_clk,
  input  logic                               rst,
  input  logic                               transmit_en,
  input  logic [DW-1:0]                      outfifo_dout,
  input  logic                               outfifo_empty,
  output logic                               outfifo_rden,
  output logic                               o_Tx_Serial,
  output logic                               o_Tx_Active,
  output logic                               transmit_Ready,
  output logic                               frame_done,
  output logic [$clog2(FRAME_WORDS+1)-1:0]   word_count
);
  localparam int CPB = CLK_FREQ_FPGA / BAUDRATE;
  localparam int NB  = DW / 8;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = NB > 1 ? $clog2(NB) : 1;
  localparam int WCW = $clog2(FRAME_WORDS + 1);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic en_q, rden_q, rden_d, done_q, done_d, load_q, load_d;
  logic tick, en_rise, last_byte, last_word;
  logic [7:0] cur;
  assign tick = cnt_q == CW'(CPB - 1);
  assign en_rise = transmit_en & ~en_q;
  assign last_byte = byte_q == BW'(NB - 1);
  assign last_word = wc_q == WCW'(FRAME_WORDS - 1);
  assign cur = MSB_FIRST ? sh_q[DW-1 -: 8] : sh_q[7:0];
  // en_q keeps sampling during reset so a switch held high across reset cannot start a frame
  always_ff @(posedge out_clk) en_q <= transmit_en;
  always_ff @(posedge out_clk)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      wc_q    <= '0;
      rden_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      wc_q    <= wc_d;
      rden_q  <= rden_d;
      done_q  <= done_d;
      load_q  <= load_d;
    end
  // FIFO data is valid the cycle after the strobe, i.e. the first START cycle, hence load_q
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = load_q ? outfifo_dout : sh_q;
    wc_d    = wc_q;
    rden_d  = 1'b0;
    done_d  = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: if (en_rise) begin
        wc_d    = '0;
        state_d = FETCH;
      end
      FETCH: if (!transmit_en) state_d = IDLE;
      else if (!outfifo_empty) begin
        rden_d  = 1'b1;
        state_d = LATCH;
      end
      LATCH: begin
        load_d  = 1'b1;
        byte_d  = '0;
        state_d = START;
      end
      START: begin
        bit_d = '0;
        if (tick) state_d = DATA;
      end
      DATA: if (tick) begin
        bit_d = bit_q + 3'd1;
        cnt_d = '0;
`ifdef UART_PARITY_EN
        if (bit_q == 3'd7) state_d = PAR;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_PARITY_EN
      PAR: if (tick) state_d = STOP;
`endif
      STOP: if (tick) begin
        if (!last_byte) begin
          byte_d  = byte_q + 1'b1;
          sh_d    = MSB_FIRST ? sh_q << 8 : sh_q >> 8;
          state_d = transmit_en ? START : IDLE;
        end else begin
          wc_d    = wc_q + 1'b1;
          done_d  = last_word;
          state_d = (last_word || !transmit_en) ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end
  assign outfifo_rden   = rden_q;
  assign o_Tx_Active    = state_q != IDLE;
  assign transmit_Ready = state_q == IDLE;
  assign frame_done     = done_q;
  assign word_count     = wc_q;
`ifdef UART_PARITY_EN
  assign o_Tx_Serial = (state_q == START) ? 1'b0 : (state_q == DATA) ? cur[bit_q] : (state_q == PAR) ? ^cur : 1'b1;
`else
  assign o_Tx_Serial = (state_q == START) ? 1'b0 : (state_q == DATA) ? cur[bit_q] : 1'b1;
`endif
endmodule

// File: tb/tb_outfifo_uart_frame_tx.sv
// tb_outfifo_uart_frame_tx: frame-level model of the UART drain checked every cycle, plus literal pins.
module tb_outfifo_uart_frame_tx;
  localparam int CPB = 10;
  localparam int NB = 4;
  localparam int FW = 3;
`ifdef UART_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int BYTE_CY = BPB * CPB;
  localparam int WORD_CY = NB * BYTE_CY;
  localparam int LOGN = 8192;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, empty = 1'b1;
  logic [31:0] dout = '0;
  logic rden0, rden1, tx0, tx1, act0, act1, rdy0, rdy1, done0, done1;
  logic [1:0] wc0, wc1;
  always #5 clk = ~clk;
  outfifo_uart_frame_tx #(.CLK_FREQ_FPGA(10000000), .BAUDRATE(1000000), .DW(32), .FRAME_WORDS(FW), .MSB_FIRST(1'b0)) dut0 (
    .out_clk(clk), .rst(rst), .transmit_en(en), .outfifo_dout(dout), .outfifo_empty(empty),
    .outfifo_rden(rden0), .o_Tx_Serial(tx0), .o_Tx_Active(act0), .transmit_Ready(rdy0),
    .frame_done(done0), .word_count(wc0));
  outfifo_uart_frame_tx #(.CLK_FREQ_FPGA(10000000), .BAUDRATE(1000000), .DW(32), .FRAME_WORDS(FW), .MSB_FIRST(1'b1)) dut1 (
    .out_clk(clk), .rst(rst), .transmit_en(en), .outfifo_dout(dout), .outfifo_empty(empty),
    .outfifo_rden(rden1), .o_Tx_Serial(tx1), .o_Tx_Active(act1), .transmit_Ready(rdy1),
    .frame_done(done1), .word_count(wc1));
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rcnt = 0, done_cnt = 0, t_r1 = 0, t_done = 0;
  bit chk = 1'b0;
  logic [31:0] fifo[$];
  logic tx0_log [0:LOGN-1];
  logic tx1_log [0:LOGN-1];
  bit wact = 1'b0, act_m = 1'b0, done_m = 1'b0, en_prev = 1'b0;
  int p = 0, wc_m = 0;
  logic [31:0] w = '0;
  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic logic exp_bit(input logic [31:0] wd, input int pos, input bit msb);
    int k, b;
    logic [7:0] byt;
    k = pos / BYTE_CY;
    b = (pos % BYTE_CY) / CPB;
    byt = 8'(msb ? wd >> (8 * (NB - 1 - k)) : wd >> (8 * k));
    if (b == 0) return 1'b0;
    if (b <= 8) return byt[b-1];
    if (BPB == 11 && b == 9) return ^byt;
    return 1'b1;
  endfunction
  function automatic logic [7:0] dec(input bit msb, input int n);
    int base;
    logic [7:0] r;
    base = t_r1 + (n / NB) * (WORD_CY + 2) + (n % NB) * BYTE_CY + 1;
    for (int j = 0; j < 8; j++) r[j] = msb ? tx1_log[base + CPB * (j + 1) + CPB / 2] : tx0_log[base + CPB * (j + 1) + CPB / 2];
    return r;
  endfunction
  // Model: a word starts the cycle after its read strobe and lasts NB bytes; decisions at each last stop cycle
  always @(negedge clk) begin
    logic e0, e1;
    bit act_n, done_n;
    int wc_n, k;
    cyc++;
    if (cyc < LOGN) begin
      tx0_log[cyc] = tx0;
      tx1_log[cyc] = tx1;
    end
    if (wact) p++;
    e0 = wact ? exp_bit(w, p, 1'b0) : 1'b1;
    e1 = wact ? exp_bit(w, p, 1'b1) : 1'b1;
    if (chk) begin
      cmp("tx_lsb", tx0, e0);
      cmp("tx_msb", tx1, e1);
      cmp("frame_done", done0, done_m);
      cmp("frame_done_msb", done1, done_m);
      cmp("tx_active", act0, act_m);
      cmp("ready", rdy0, !act_m);
      cmp("word_count", wc0, wc_m);
      cmp("rden_while_empty", rden0 & empty, 1'b0);
      cmp("rden_msb", rden1, rden0);
    end
    if (done0) begin
      done_cnt++;
      t_done = cyc;
    end
    act_n = act_m;
    done_n = 1'b0;
    wc_n = wc_m;
    if (!rst) begin
      act_n = 1'b0;
      wact = 1'b0;
      wc_n = 0;
    end else if (!act_m) begin
      if (en && !en_prev) begin
        act_n = 1'b1;
        wc_n = 0;
      end
    end else if (wact && (p + 1) % BYTE_CY == 0) begin
      k = p / BYTE_CY;
      if (k < NB - 1) begin
        if (!en) begin
          act_n = 1'b0;
          wact = 1'b0;
        end
      end else begin
        wact = 1'b0;
        wc_n = wc_m + 1;
        if (wc_n == FW) begin
          done_n = 1'b1;
          act_n = 1'b0;
        end else act_n = en;
      end
    end else if (!wact && !rden0) act_n = en;
    if (rden0) begin
      if (rcnt == 0) t_r1 = cyc;
      rcnt++;
      if (fifo.size() > 0) dout = fifo.pop_front();
      empty = fifo.size() == 0;
      if (rst) begin
        wact = 1'b1;
        w = dout;
        p = -1;
      end
    end
    en_prev = en;
    act_m = act_n;
    done_m = done_n;
    wc_m = wc_n;
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] d);
    fifo.push_back(d);
    empty = 1'b0;
  endtask
  task automatic clr;
    rcnt = 0;
    done_cnt = 0;
  endtask
  logic [7:0] lsb_exp [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
  logic [7:0] msb_exp [12] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99};
  initial begin
    step(2);
    chk = 1'b1;
    step(1);
    cmp("reset_tx", tx0, 1'b1);
    cmp("reset_ready", rdy0, 1'b1);
    cmp("reset_wc", wc0, 2'd0);
    rst = 1'b1;
    step(3);
    // T1/T2: full frame, both byte orders
    clr();
    push(32'h44332211);
    push(32'h88776655);
    push(32'hCCBBAA99);
    en = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step(1);
    cmp("t1_done_seen", done_cnt, 1);
    step(20);
    cmp("t1_rden_count", rcnt, 3);
    cmp("t1_word_count", wc0, 2'd3);
    cmp("t1_done_count", done_cnt, 1);
    cmp("t1_no_restart", rdy0, 1'b1);
    cmp("t1_done_latency", t_done - t_r1, 2 * (WORD_CY + 2) + WORD_CY + 1);
    for (int n = 0; n < 12; n++) begin
      cmp("t1_byte_lsb", dec(1'b0, n), lsb_exp[n]);
      cmp("t2_byte_msb", dec(1'b1, n), msb_exp[n]);
    end
    en = 1'b0;
    step(3);
    // T3: underrun stall after the first word
    clr();
    push(32'h04030201);
    en = 1'b1;
    step(500);
    cmp("t3_stall_rden", rcnt, 1);
    cmp("t3_stall_line", tx0, 1'b1);
    cmp("t3_stall_active", act0, 1'b1);
    push(32'h08070605);
    push(32'h0C0B0A09);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) step(1);
    cmp("t3_done_seen", done_cnt, 1);
    cmp("t3_rden_count", rcnt, 3);
    cmp("t3_word_count", wc0, 2'd3);
    en = 1'b0;
    step(3);
    // T4: abort during data bits of byte 6
    clr();
    push(32'hDEADBEEF);
    push(32'h5A5AA5A5);
    push(32'h0F0F0F0F);
    en = 1'b1;
    for (int i = 0; i < 1000 && rcnt < 2; i++) step(1);
    cmp("t4_second_read", rcnt, 2);
    step(130);
    en = 1'b0;
    step(300);
    cmp("t4_rden_count", rcnt, 2);
    cmp("t4_no_done", done_cnt, 0);
    cmp("t4_word_count", wc0, 2'd1);
    cmp("t4_ready", rdy0, 1'b1);
    fifo.delete();
    empty = 1'b1;
    step(3);
    // T5: reset mid data bit, switch held high across release
    clr();
    push(32'h12345678);
    en = 1'b1;
    for (int i = 0; i < 100 && rcnt < 1; i++) step(1);
    step(40);
    rst = 1'b0;
    step(1);
    cmp("t5_tx", tx0, 1'b1);
    cmp("t5_rden", rden0, 1'b0);
    cmp("t5_active", act0, 1'b0);
    cmp("t5_wc", wc0, 2'd0);
    step(2);
    rst = 1'b1;
    step(50);
    cmp("t5_no_start", rdy0, 1'b1);
    cmp("t5_rden_count", rcnt, 1);
    en = 1'b0;
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
